ecc_operand_loader: RTL and testbench

- Upstream front end for the ECC ElGamal top (final_top). It accepts the five 256-bit operands (Gx, Gy, alice, bob, message) as 32-bit word writes from a narrow host bus.
- It range-checks the operands against the field prime, then issues a one-cycle start pulse to the core.
- It supervises the run until the core's Done, or until a timeout expires, and reports status back to the host.

---
 rtl/ecc_pkg.sv | 41 ++++
 rtl/mag_compare_256.sv | 12 +
 rtl/ecc_operand_loader.sv | 203 ++++++++++++++++++++
 tb/tb_ecc_operand_loader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC ElGamal front end: FSM states, error codes,
// operand selects and the secp256k1 domain constants.
package ecc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_INCOMPLETE = 2'd1;
  localparam logic [1:0] ERR_RANGE      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT    = 2'd3;

  localparam logic [2:0] SEL_GX    = 3'd0;
  localparam logic [2:0] SEL_GY    = 3'd1;
  localparam logic [2:0] SEL_ALICE = 3'd2;
  localparam logic [2:0] SEL_BOB   = 3'd3;
  localparam logic [2:0] SEL_MSG   = 3'd4;

  localparam int NUM_OPS      = 5;
  localparam int WORDS_PER_OP = 8;
  localparam int NUM_WORDS    = NUM_OPS * WORDS_PER_OP;

  localparam logic [255:0] SECP_P  =
    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam logic [255:0] SECP_GX =
    256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] SECP_GY =
    256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;

  // Selects 5-7 do not map to an operand register.
  function automatic logic sel_valid(input logic [2:0] sel);
    return (sel <= SEL_MSG);
  endfunction

endpackage

// File: rtl/mag_compare_256.sv
// Combinational 256-bit unsigned magnitude compare (a < b) plus a == 0 detect.
module mag_compare_256 (
  input  logic [255:0] a_i,
  input  logic [255:0] b_i,
  output logic         lt_o,
  output logic         a_zero_o
);

  assign lt_o     = (a_i < b_i);
  assign a_zero_o = (a_i == '0);

endmodule

// File: rtl/ecc_operand_loader.sv
// Host-side loader for the ECC ElGamal core: collects five 256-bit operands
// through 32-bit word writes, range-checks them, pulses start and supervises
// the run until Done or a cycle timeout.
module ecc_operand_loader
  import ecc_pkg::*;
#(
  parameter logic [255:0] P              = SECP_P,
  parameter logic [31:0]  TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         wr_en,
  input  logic [5:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic         go,
  input  logic         clr,
  input  logic         Done,
  output logic [255:0] Gx,
  output logic [255:0] Gy,
  output logic [255:0] alice,
  output logic [255:0] bob,
  output logic [255:0] message,
  output logic         start,
  output logic         busy,
  output logic         done_o,
  output logic [1:0]   err_code,
  output logic         wr_rejected
);

  state_e                    state_q, state_d;
  logic [1:0]                err_q, err_d;
  logic [NUM_OPS-1:0][255:0] ops_q, ops_d;
  logic [NUM_WORDS-1:0]      mask_q, mask_d;
  logic                      rej_q, rej_d;
  logic [31:0]               cnt_q, cnt_d;
  logic                      chk_ok_q, chk_ok_d;

  logic [2:0] wr_sel;
  logic [2:0] wr_word;
  logic       host_st;
  logic       wr_acc;
  logic       wr_rej;
  logic       mask_full;
  logic       clr_acc;
  logic       timeout_hit;

  assign wr_sel      = wr_addr[5:3];
  assign wr_word     = wr_addr[2:0];
  // The operand bank is only writable while the core is not using it.
  assign host_st     = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
  assign wr_acc      = wr_en && host_st && sel_valid(wr_sel);
  assign wr_rej      = wr_en && !wr_acc;
  assign mask_full   = &mask_q;
  assign clr_acc     = clr && ((state_q == S_DONE) || (state_q == S_ERR));
  assign timeout_hit = (cnt_q == (TIMEOUT_CYCLES - 32'd1));

  // One comparator per operand lane against P; Gx, Gy and message use the
  // less-than result, alice and bob use the zero detect.
  logic [NUM_OPS-1:0] lt_v;
  logic [NUM_OPS-1:0] zero_v;

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_cmp
    mag_compare_256 u_cmp (
      .a_i      (ops_q[i]),
      .b_i      (P),
      .lt_o     (lt_v[i]),
      .a_zero_o (zero_v[i])
    );
  end

  logic unused_cmp;
  assign unused_cmp = ^{lt_v[SEL_BOB], lt_v[SEL_ALICE], zero_v[SEL_MSG],
                        zero_v[SEL_GY], zero_v[SEL_GX]};

  logic range_ok;
  assign range_ok = lt_v[SEL_GX] && lt_v[SEL_GY] && lt_v[SEL_MSG] &&
                    !zero_v[SEL_ALICE] && !zero_v[SEL_BOB];

  // State and error-code register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; go from DONE/ERR follows the IDLE rules, clr wins over go.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          if (mask_full) begin
            state_d = S_CHECK;
            err_d   = ERR_NONE;
          end else begin
            state_d = S_ERR;
            err_d   = ERR_INCOMPLETE;
          end
        end
      end
      S_CHECK: state_d = S_LAUNCH;
      S_LAUNCH: begin
        if (chk_ok_q) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_ERR;
          err_d   = ERR_RANGE;
        end
      end
      S_WAIT: begin
        if (Done) begin
          state_d = S_DONE;
        end else if (timeout_hit) begin
          state_d = S_ERR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_DONE, S_ERR: begin
        if (clr) begin
          state_d = S_IDLE;
          err_d   = ERR_NONE;
        end else if (go) begin
          if (mask_full) begin
            state_d = S_CHECK;
            err_d   = ERR_NONE;
          end else begin
            state_d = S_ERR;
            err_d   = ERR_INCOMPLETE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        err_d   = ERR_NONE;
      end
    endcase
  end

  // Datapath next-state: operand words, load mask, sticky reject, timeout
  // counter and the registered check result.
  always_comb begin
    ops_d    = ops_q;
    mask_d   = mask_q;
    rej_d    = rej_q;
    cnt_d    = cnt_q;
    chk_ok_d = chk_ok_q;
    if (clr_acc) begin
      mask_d = '0;
      rej_d  = 1'b0;
    end
    if (wr_acc) begin
      ops_d[wr_sel][{wr_word, 5'd0} +: 32] = wr_data;
      mask_d[{wr_sel, wr_word}]            = 1'b1;
    end
    if (wr_rej) begin
      rej_d = 1'b1;
    end
    case (state_q)
      S_CHECK:  chk_ok_d = range_ok;
      S_LAUNCH: cnt_d    = '0;
      S_WAIT:   if (!Done && !timeout_hit) cnt_d = cnt_q + 32'd1;
      default:  ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ops_q    <= '0;
      mask_q   <= '0;
      rej_q    <= 1'b0;
      cnt_q    <= '0;
      chk_ok_q <= 1'b0;
    end else begin
      ops_q    <= ops_d;
      mask_q   <= mask_d;
      rej_q    <= rej_d;
      cnt_q    <= cnt_d;
      chk_ok_q <= chk_ok_d;
    end
  end

  // Moore outputs; start only fires from LAUNCH when every check passed.
  always_comb begin
    start    = (state_q == S_LAUNCH) && chk_ok_q;
    busy     = (state_q == S_CHECK) || (state_q == S_LAUNCH) || (state_q == S_WAIT);
    done_o   = (state_q == S_DONE);
    err_code = (state_q == S_ERR) ? err_q : ERR_NONE;
  end

  assign wr_rejected = rej_q;
  assign Gx          = ops_q[SEL_GX];
  assign Gy          = ops_q[SEL_GY];
  assign alice       = ops_q[SEL_ALICE];
  assign bob         = ops_q[SEL_BOB];
  assign message     = ops_q[SEL_MSG];

endmodule

// File: tb/tb_ecc_operand_loader.sv
// Scoreboard bench for ecc_operand_loader: the stimulus queues the start /
// done / error events it expects (with the cycle they must appear in) and a
// negedge monitor pops and compares every event either DUT produces.
`timescale 1ns/1ps
module tb_ecc_operand_loader;
  import ecc_pkg::*;

  localparam logic [255:0] MSG  =
    256'hECE38500111122223333444455556666777788889999AAAABBBBCCCC0000ECE3;
  localparam logic [255:0] P_M1 =
    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2E;
  localparam int K_START = 0;
  localparam int K_DONE  = 1;
  localparam int K_ERR   = 2;

  logic         Clk, Reset, wr_en, go, go2, clr, Done, Done2;
  logic [5:0]   wr_addr;
  logic [31:0]  wr_data;
  logic [255:0] Gx, Gy, alice, bob, message;
  logic [255:0] Gx2, Gy2, alice2, bob2, message2;
  logic         start, busy, done_o, wr_rejected;
  logic         start2, busy2, done2, wr_rejected2;
  logic [1:0]   err_code, err_code2;

  ecc_operand_loader dut (
    .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .go(go), .clr(clr), .Done(Done),
    .Gx(Gx), .Gy(Gy), .alice(alice), .bob(bob), .message(message),
    .start(start), .busy(busy), .done_o(done_o), .err_code(err_code),
    .wr_rejected(wr_rejected)
  );

  // Short-timeout instance: shares the write bus, clr and Reset, but has its
  // own go and Done so it only runs when the timeout scenario launches it.
  ecc_operand_loader #(.TIMEOUT_CYCLES(32'd16)) dut_to (
    .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .go(go2), .clr(clr), .Done(Done2),
    .Gx(Gx2), .Gy(Gy2), .alice(alice2), .bob(bob2), .message(message2),
    .start(start2), .busy(busy2), .done_o(done2), .err_code(err_code2),
    .wr_rejected(wr_rejected2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int inst;
    int kind;
    int code;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  task automatic expect_evt(input int inst, input int kind, input int code, input int c);
    exp_t e;
    e.inst = inst; e.kind = kind; e.code = code; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic mon_evt(input int inst, input int kind, input int code);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got inst=%0d kind=%0d code=%0d cyc=%0d, want no event",
               inst, kind, code, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.inst != inst || e.kind != kind || e.code != code || e.cyc != cyc) begin
        bad++;
        $display("FAIL event: got inst=%0d kind=%0d code=%0d cyc=%0d, want inst=%0d kind=%0d code=%0d cyc=%0d",
                 inst, kind, code, cyc, e.inst, e.kind, e.code, e.cyc);
      end
    end
  endtask

  logic       pd0 = 1'b0, pd1 = 1'b0;
  logic [1:0] pe0 = 2'd0, pe1 = 2'd0;

  // Monitor: every start-high cycle, every rise of done_o and every change to
  // a non-zero error code is an event that must match the queue head.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (start)                                 mon_evt(0, K_START, 0);
      if (done_o && !pd0)                        mon_evt(0, K_DONE, 0);
      if (err_code != 2'd0 && err_code != pe0)   mon_evt(0, K_ERR, int'(err_code));
      if (start2)                                mon_evt(1, K_START, 0);
      if (done2 && !pd1)                         mon_evt(1, K_DONE, 0);
      if (err_code2 != 2'd0 && err_code2 != pe1) mon_evt(1, K_ERR, int'(err_code2));
    end
    pd0 <= done_o;
    pd1 <= done2;
    pe0 <= err_code;
    pe1 <= err_code2;
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_op(input int sel, input logic [255:0] v, input int skip_word);
    for (int w = 0; w < 8; w++)
      if (w != skip_word) wr(6'(sel * 8 + w), v[w*32 +: 32]);
  endtask

  task automatic load_all(input logic [255:0] gx, input logic [255:0] gy);
    load_op(0, gx, -1);
    load_op(1, gy, -1);
    load_op(2, 256'd3, -1);
    load_op(3, 256'd5, -1);
    load_op(4, MSG, -1);
  endtask

  // Returns the cycle count seen while go was being driven; the go edge is c0+1.
  task automatic pulse_go(input int inst, output int c0);
    c0 = cyc;
    if (inst == 0) go = 1'b1; else go2 = 1'b1;
    tick();
    go = 1'b0; go2 = 1'b0;
  endtask

  initial begin
    int c0, s;
    Reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    go = 1'b0; go2 = 1'b0; clr = 1'b0; Done = 1'b0; Done2 = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_code, 0);
    chk("rst_rej", wr_rejected, 0);
    chk("rst_gx", Gx, 0);
    chk("rst_msg", message, 0);
    Reset = 1'b0;
    tick();

    // 1: full load, launch, Done 100 cycles after start
    load_all(SECP_GX, SECP_GY);
    chk("t1_gx", Gx, SECP_GX);
    chk("t1_gy", Gy, SECP_GY);
    chk("t1_alice", alice, 256'd3);
    chk("t1_msg", message, MSG);
    pulse_go(0, c0);
    expect_evt(0, K_START, 0, c0 + 2);
    chk("t1_busy_after_go", busy, 1);
    s = c0 + 2;
    run_to(s + 100);
    Done = 1'b1;
    expect_evt(0, K_DONE, 0, s + 101);
    tick();
    Done = 1'b0;
    chk("t1_done", done_o, 1);
    chk("t1_err", err_code, 0);
    chk("t1_busy_done", busy, 0);

    // 2: 39 words (bob word 7 missing) -> incomplete load
    clr = 1'b1; tick(); clr = 1'b0;
    load_op(0, SECP_GX, -1);
    load_op(1, SECP_GY, -1);
    load_op(2, 256'd3, -1);
    load_op(3, 256'd5, 7);
    load_op(4, MSG, -1);
    pulse_go(0, c0);
    expect_evt(0, K_ERR, 1, c0 + 1);
    chk("t2_busy0", busy, 0);
    tick();
    chk("t2_busy1", busy, 0);
    chk("t2_err", err_code, 1);

    // 3: Gy = P fails the range check; Gy = P-1 then launches
    clr = 1'b1; tick(); clr = 1'b0;
    load_all(SECP_GX, SECP_P);
    pulse_go(0, c0);
    expect_evt(0, K_ERR, 2, c0 + 3);
    chk("t3_busy_check", busy, 1);
    run_to(c0 + 3);
    chk("t3_err", err_code, 2);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t3_clr_err", err_code, 0);
    load_all(SECP_GX, P_M1);
    chk("t3_gy", Gy, P_M1);
    pulse_go(0, c0);
    expect_evt(0, K_START, 0, c0 + 2);
    s = c0 + 2;
    run_to(s + 5);
    Done = 1'b1;
    expect_evt(0, K_DONE, 0, s + 6);
    tick();
    Done = 1'b0;
    chk("t3_done", done_o, 1);
    clr = 1'b1; tick(); clr = 1'b0;

    // 4: short-timeout instance; it holds a full mask from the earlier loads.
    // Sixteen WAIT cycles follow the start cycle; the error registers on the
    // edge that closes the 16th.
    pulse_go(1, c0);
    expect_evt(1, K_START, 0, c0 + 2);
    s = c0 + 2;
    expect_evt(1, K_ERR, 3, s + 17);
    run_to(s + 16);
    chk("t4_busy_last_wait", busy2, 1);
    chk("t4_err_not_yet", err_code2, 0);
    tick();
    chk("t4_err_timeout", err_code2, 3);
    chk("t4_busy_err", busy2, 0);
    // Done on the same cycle as the timeout resolves to DONE
    pulse_go(1, c0);
    expect_evt(1, K_START, 0, c0 + 2);
    s = c0 + 2;
    run_to(s + 16);
    Done2 = 1'b1;
    expect_evt(1, K_DONE, 0, s + 17);
    tick();
    Done2 = 1'b0;
    chk("t4_done_tie", done2, 1);
    chk("t4_err_tie", err_code2, 0);

    // 5: writes rejected during WAIT and with select 5
    load_all(SECP_GX, SECP_GY);
    pulse_go(0, c0);
    expect_evt(0, K_START, 0, c0 + 2);
    s = c0 + 2;
    run_to(s + 3);
    wr(6'o10, 32'hDEADBEEF);
    chk("t5_gy_kept", Gy, SECP_GY);
    chk("t5_rej_wait", wr_rejected, 1);
    chk("t5_busy", busy, 1);
    Done = 1'b1;
    expect_evt(0, K_DONE, 0, cyc + 1);
    tick();
    Done = 1'b0;
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t5_rej_clr", wr_rejected, 0);
    wr(6'o50, 32'h12345678);
    chk("t5_rej_sel5", wr_rejected, 1);
    chk("t5_gx_kept", Gx, SECP_GX);

    // 6: reset mid-WAIT clears everything; go afterwards sees an empty mask
    load_all(SECP_GX, SECP_GY);
    pulse_go(0, c0);
    expect_evt(0, K_START, 0, c0 + 2);
    s = c0 + 2;
    run_to(s + 4);
    chk("t6_busy_pre", busy, 1);
    Reset = 1'b1;
    tick();
    chk("t6_start", start, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done_o, 0);
    chk("t6_err", err_code, 0);
    chk("t6_rej", wr_rejected, 0);
    chk("t6_gx", Gx, 0);
    chk("t6_gy", Gy, 0);
    chk("t6_alice", alice, 0);
    chk("t6_bob", bob, 0);
    chk("t6_msg", message, 0);
    Reset = 1'b0;
    pulse_go(0, c0);
    expect_evt(0, K_ERR, 1, c0 + 1);
    tick();
    chk("t6_err_incomplete", err_code, 1);

    repeat (5) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_events: got %0d still pending (first inst=%0d kind=%0d cyc=%0d), want 0",
               exp_q.size(), exp_q[0].inst, exp_q[0].kind, exp_q[0].cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
